// File: rtl/sprite_renderer_if.sv
// Signal bundle between the VGA timing source / sprite memory and the sprite renderer.
// The master side drives counts, syncs, sprite controls and read data; the renderer is the slave.
interface sprite_renderer_if;
    logic [9:0]  i_Col_Count;
    logic [9:0]  i_Row_Count;
    logic        i_HSync;
    logic        i_VSync;
    logic [9:0]  i_Sprite_X;
    logic [9:0]  i_Sprite_Y;
    logic        i_Flip_H;
    logic [8:0]  i_Bg_Color;
    logic [9:0]  o_Read_Addr;
    logic [8:0]  i_Read_Data;
    logic [2:0]  o_Red;
    logic [2:0]  o_Green;
    logic [2:0]  o_Blue;
    logic        o_HSync;
    logic        o_VSync;
    logic        o_Hit;
    logic [10:0] o_Frame_Hits;

    modport master (
        output i_Col_Count, i_Row_Count, i_HSync, i_VSync,
        output i_Sprite_X, i_Sprite_Y, i_Flip_H, i_Bg_Color, i_Read_Data,
        input  o_Read_Addr, o_Red, o_Green, o_Blue, o_HSync, o_VSync, o_Hit, o_Frame_Hits
    );

    modport slave (
        input  i_Col_Count, i_Row_Count, i_HSync, i_VSync,
        input  i_Sprite_X, i_Sprite_Y, i_Flip_H, i_Bg_Color, i_Read_Data,
        output o_Read_Addr, o_Red, o_Green, o_Blue, o_HSync, o_VSync, o_Hit, o_Frame_Hits
    );
endinterface

// File: rtl/sprite_renderer.sv
// Three-stage sprite overlay: address generation, sprite memory read, colour-key mux.
// Syncs travel alongside the pixel so colour and sync leave the block aligned.
module sprite_renderer #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter logic [8:0]  TRANSPARENT = 9'b111_000_111
) (
    input logic              i_Clk,
    input logic              i_Rst_n,
    sprite_renderer_if.slave bus
);
    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    logic [9:0]  x_r;
    logic [9:0]  y_r;
    logic        flip_r;
    logic [9:0]  addr_r;
    logic        inside1_r;
    logic        active1_r;
    logic        hsync1_r;
    logic        vsync1_r;
    logic        inside2_r;
    logic        active2_r;
    logic        hsync2_r;
    logic        vsync2_r;
    logic [8:0]  rgb_r;
    logic        hit_r;
    logic        hsync3_r;
    logic        vsync3_r;
    logic [10:0] count_r;
    logic [10:0] frame_hits_r;

    logic        active_s;
    logic        frame_start_s;
    logic        inside_s;
    logic [4:0]  dx_s;
    logic [4:0]  dy_s;
    logic [9:0]  addr_s;
    logic [8:0]  rgb_s;
    logic        hit_s;

    // Stage-1 decode; the 11-bit compare keeps X+32 from wrapping past column 1023.
    always_comb begin
        active_s      = (bus.i_Col_Count < H_LIM) && (bus.i_Row_Count < V_LIM);
        frame_start_s = (bus.i_Row_Count == V_LIM) && (bus.i_Col_Count == 10'd0);
        inside_s      = ({1'b0, bus.i_Col_Count} >= {1'b0, x_r}) &&
                        ({1'b0, bus.i_Col_Count} <  ({1'b0, x_r} + 11'd32)) &&
                        ({1'b0, bus.i_Row_Count} >= {1'b0, y_r}) &&
                        ({1'b0, bus.i_Row_Count} <  ({1'b0, y_r} + 11'd32)) &&
                        active_s;
        dx_s = bus.i_Col_Count[4:0] - x_r[4:0];
        dy_s = bus.i_Row_Count[4:0] - y_r[4:0];
        if (inside_s) begin
            addr_s = {dy_s, (flip_r ? ~dx_s : dx_s)};
        end else begin
            addr_s = 10'd0;
        end
    end

    // Output colour select using the pixel the memory returned for stage-1's address.
    always_comb begin
        rgb_s = 9'd0;
        hit_s = 1'b0;
        if (!active2_r) begin
            rgb_s = 9'd0;
            hit_s = 1'b0;
        end else if (inside2_r && (bus.i_Read_Data != TRANSPARENT)) begin
            rgb_s = bus.i_Read_Data;
            hit_s = 1'b1;
        end else begin
            rgb_s = bus.i_Bg_Color;
            hit_s = 1'b0;
        end
    end

    // Sprite position only moves at frame start so a frame never tears.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            x_r    <= 10'd1023;
            y_r    <= 10'd1023;
            flip_r <= 1'b0;
        end else if (frame_start_s) begin
            x_r    <= bus.i_Sprite_X;
            y_r    <= bus.i_Sprite_Y;
            flip_r <= bus.i_Flip_H;
        end else begin
            x_r    <= x_r;
            y_r    <= y_r;
            flip_r <= flip_r;
        end
    end

    // Pixel pipeline: address/flags, memory-latency delay, registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            addr_r    <= 10'd0;
            inside1_r <= 1'b0;
            active1_r <= 1'b0;
            hsync1_r  <= 1'b1;
            vsync1_r  <= 1'b1;
            inside2_r <= 1'b0;
            active2_r <= 1'b0;
            hsync2_r  <= 1'b1;
            vsync2_r  <= 1'b1;
            rgb_r     <= 9'd0;
            hit_r     <= 1'b0;
            hsync3_r  <= 1'b1;
            vsync3_r  <= 1'b1;
        end else begin
            addr_r    <= addr_s;
            inside1_r <= inside_s;
            active1_r <= active_s;
            hsync1_r  <= bus.i_HSync;
            vsync1_r  <= bus.i_VSync;
            inside2_r <= inside1_r;
            active2_r <= active1_r;
            hsync2_r  <= hsync1_r;
            vsync2_r  <= vsync1_r;
            rgb_r     <= rgb_s;
            hit_r     <= hit_s;
            hsync3_r  <= hsync2_r;
            vsync3_r  <= vsync2_r;
        end
    end

    // Per-frame opaque-pixel count; a hit on the frame-start edge still belongs to the old frame.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            count_r      <= 11'd0;
            frame_hits_r <= 11'd0;
        end else if (frame_start_s) begin
            count_r      <= 11'd0;
            frame_hits_r <= count_r + {10'd0, hit_r};
        end else if (hit_r) begin
            count_r      <= count_r + 11'd1;
            frame_hits_r <= frame_hits_r;
        end else begin
            count_r      <= count_r;
            frame_hits_r <= frame_hits_r;
        end
    end

    assign bus.o_Read_Addr  = addr_r;
    assign bus.o_Red        = rgb_r[8:6];
    assign bus.o_Green      = rgb_r[5:3];
    assign bus.o_Blue       = rgb_r[2:0];
    assign bus.o_Hit        = hit_r;
    assign bus.o_HSync      = hsync3_r;
    assign bus.o_VSync      = vsync3_r;
    assign bus.o_Frame_Hits = frame_hits_r;
endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: a table of single-pixel vectors plus
// scripted frame sequences for clipping, hit counting, no-tearing and reset.
module tb_sprite_renderer;
    localparam logic [8:0] BG  = 9'h0A5;
    localparam logic [8:0] KEY = 9'h1C7;
    localparam logic [8:0] OPQ = 9'h0AA;

    typedef struct {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic [9:0] exp_addr;
        logic [8:0] exp_rgb;
        logic       exp_hit;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_renderer_if bus();

    sprite_renderer dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus.slave)
    );

    logic [8:0] rom [0:1023];
    logic [8:0] rd_data;
    always @(posedge clk) rd_data <= rom[bus.o_Read_Addr];
    assign bus.i_Read_Data = rd_data;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] c, input logic [9:0] r, input logic hs, input logic vs);
        bus.i_Col_Count = c;
        bus.i_Row_Count = r;
        bus.i_HSync     = hs;
        bus.i_VSync     = vs;
    endtask

    task automatic idle();
        drive(10'd700, 10'd490, 1'b1, 1'b1);
    endtask

    // mode 0: a ^ 0x0AA (key value replaced by 0); 1: all OPQ; 2: all KEY except address 0
    task automatic fill_rom(input int mode);
        logic [8:0] v;
        for (int a = 0; a < 1024; a++) begin
            v = 9'(a) ^ OPQ;
            if (v == KEY) v = 9'h000;
            if (mode == 1) v = OPQ;
            if (mode == 2) v = (a == 0) ? OPQ : KEY;
            rom[a] = v;
        end
    endtask

    task automatic apply(input vec_t v);
        string tag;
        tag = $sformatf("(%0d,%0d)", v.col, v.row);
        @(negedge clk);
        drive(v.col, v.row, v.hs, v.vs);
        @(negedge clk);
        idle();
        chk({tag, " addr"}, 32'(bus.o_Read_Addr), 32'(v.exp_addr));
        @(negedge clk);
        @(negedge clk);
        chk({tag, " rgb"}, 32'({bus.o_Red, bus.o_Green, bus.o_Blue}), 32'(v.exp_rgb));
        chk({tag, " hit"}, 32'(bus.o_Hit), 32'(v.exp_hit));
        chk({tag, " hsync"}, 32'(bus.o_HSync), 32'(v.hs));
        chk({tag, " vsync"}, 32'(bus.o_VSync), 32'(v.vs));
    endtask

    task automatic frame_start(input logic [9:0] x, input logic [9:0] y, input logic f);
        @(negedge clk);
        bus.i_Sprite_X = x;
        bus.i_Sprite_Y = y;
        bus.i_Flip_H   = f;
        drive(10'd0, 10'd480, 1'b1, 1'b0);
        @(negedge clk);
        idle();
    endtask

    task automatic scan(input int r0, input int r1, input int c0, input int c1, output int hits);
        hits = 0;
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                @(negedge clk);
                hits = hits + int'(bus.o_Hit);
                drive(10'(c), 10'(r), 1'b1, 1'b1);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hits = hits + int'(bus.o_Hit);
            idle();
        end
    endtask

    vec_t va[11];
    vec_t vb[4];
    vec_t vs1;
    int   hits;

    initial begin
        va[0]  = '{10'd100, 10'd50,  1'b1, 1'b1, 10'd0,    9'h0AA, 1'b1};
        va[1]  = '{10'd101, 10'd50,  1'b1, 1'b1, 10'd1,    9'h0AB, 1'b1};
        va[2]  = '{10'd131, 10'd81,  1'b1, 1'b1, 10'd1023, 9'h155, 1'b1};
        va[3]  = '{10'd132, 10'd81,  1'b1, 1'b1, 10'd0,    BG,     1'b0};
        va[4]  = '{10'd99,  10'd50,  1'b1, 1'b1, 10'd0,    BG,     1'b0};
        va[5]  = '{10'd100, 10'd49,  1'b1, 1'b1, 10'd0,    BG,     1'b0};
        va[6]  = '{10'd100, 10'd82,  1'b1, 1'b1, 10'd0,    BG,     1'b0};
        va[7]  = '{10'd105, 10'd52,  1'b1, 1'b1, 10'd69,   9'h0EF, 1'b1};
        va[8]  = '{10'd700, 10'd50,  1'b0, 1'b1, 10'd0,    9'h000, 1'b0};
        va[9]  = '{10'd639, 10'd479, 1'b1, 1'b1, 10'd0,    BG,     1'b0};
        va[10] = '{10'd10,  10'd490, 1'b1, 1'b0, 10'd0,    9'h000, 1'b0};
        vb[0]  = '{10'd100, 10'd50,  1'b1, 1'b1, 10'd31,   9'h0B5, 1'b1};
        vb[1]  = '{10'd131, 10'd50,  1'b1, 1'b1, 10'd0,    9'h0AA, 1'b1};
        vb[2]  = '{10'd131, 10'd81,  1'b1, 1'b1, 10'd992,  9'h14A, 1'b1};
        vb[3]  = '{10'd110, 10'd60,  1'b1, 1'b1, 10'd341,  9'h1FF, 1'b1};

        fill_rom(0);
        bus.i_Sprite_X = 10'd100;
        bus.i_Sprite_Y = 10'd50;
        bus.i_Flip_H   = 1'b0;
        bus.i_Bg_Color = BG;
        idle();

        // Reset state while held
        repeat (3) @(negedge clk);
        chk("rst rgb", 32'({bus.o_Red, bus.o_Green, bus.o_Blue}), 32'd0);
        chk("rst hit", 32'(bus.o_Hit), 32'd0);
        chk("rst hsync", 32'(bus.o_HSync), 32'd1);
        chk("rst vsync", 32'(bus.o_VSync), 32'd1);
        chk("rst addr", 32'(bus.o_Read_Addr), 32'd0);
        chk("rst frame_hits", 32'(bus.o_Frame_Hits), 32'd0);
        rst_n = 1'b1;

        // Before any frame start the sprite is parked off-screen
        vs1 = '{10'd100, 10'd50, 1'b1, 1'b1, 10'd0, BG, 1'b0};
        apply(vs1);

        frame_start(10'd100, 10'd50, 1'b0);
        chk("first frame_hits", 32'(bus.o_Frame_Hits), 32'd0);
        for (int i = 0; i < 11; i++) apply(va[i]);

        frame_start(10'd100, 10'd50, 1'b1);
        for (int i = 0; i < 4; i++) apply(vb[i]);

        // Single opaque texel in a keyed sprite
        fill_rom(2);
        frame_start(10'd100, 10'd50, 1'b0);
        scan(48, 83, 98, 134, hits);
        chk("keyed scan hits", 32'(hits), 32'd1);
        frame_start(10'd100, 10'd50, 1'b0);
        chk("keyed frame_hits", 32'(bus.o_Frame_Hits), 32'd1);

        // Bottom-right clipping
        fill_rom(1);
        frame_start(10'd620, 10'd470, 1'b0);
        scan(468, 479, 610, 645, hits);
        chk("clip scan hits", 32'(hits), 32'd200);
        vs1 = '{10'd0, 10'd470, 1'b1, 1'b1, 10'd0, BG, 1'b0};
        apply(vs1);
        vs1 = '{10'd620, 10'd0, 1'b1, 1'b1, 10'd0, BG, 1'b0};
        apply(vs1);
        frame_start(10'd620, 10'd470, 1'b0);
        chk("clip frame_hits", 32'(bus.o_Frame_Hits), 32'd200);
        vs1 = '{10'd639, 10'd479, 1'b1, 1'b1, 10'd307, OPQ, 1'b1};
        apply(vs1);
        vs1 = '{10'd640, 10'd479, 1'b1, 1'b1, 10'd0, 9'h000, 1'b0};
        apply(vs1);

        // Mid-frame position change must wait for the next frame start
        frame_start(10'd100, 10'd190, 1'b0);
        @(negedge clk);
        drive(10'd50, 10'd200, 1'b1, 1'b1);
        bus.i_Sprite_X = 10'd300;
        @(negedge clk);
        idle();
        vs1 = '{10'd100, 10'd205, 1'b1, 1'b1, 10'd480, OPQ, 1'b1};
        apply(vs1);
        apply(vs1);
        vs1 = '{10'd300, 10'd205, 1'b1, 1'b1, 10'd0, BG, 1'b0};
        apply(vs1);
        frame_start(10'd300, 10'd190, 1'b0);
        chk("tear frame_hits", 32'(bus.o_Frame_Hits), 32'd2);
        vs1 = '{10'd300, 10'd205, 1'b1, 1'b1, 10'd480, OPQ, 1'b1};
        apply(vs1);
        vs1 = '{10'd100, 10'd205, 1'b1, 1'b1, 10'd0, BG, 1'b0};
        apply(vs1);

        // Asynchronous reset mid-line, then sync re-alignment after release
        @(negedge clk);
        drive(10'd300, 10'd205, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("pre-rst hit", 32'(bus.o_Hit), 32'd1);
        chk("pre-rst hsync", 32'(bus.o_HSync), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rgb", 32'({bus.o_Red, bus.o_Green, bus.o_Blue}), 32'd0);
        chk("async hit", 32'(bus.o_Hit), 32'd0);
        chk("async hsync", 32'(bus.o_HSync), 32'd1);
        chk("async vsync", 32'(bus.o_VSync), 32'd1);
        chk("async addr", 32'(bus.o_Read_Addr), 32'd0);
        chk("async frame_hits", 32'(bus.o_Frame_Hits), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release hsync 2cyc", 32'(bus.o_HSync), 32'd1);
        @(negedge clk);
        chk("release hsync 3cyc", 32'(bus.o_HSync), 32'd0);
        chk("release hit", 32'(bus.o_Hit), 32'd0);
        chk("release rgb", 32'({bus.o_Red, bus.o_Green, bus.o_Blue}), 32'(BG));
        idle();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Pixel-pipeline stage that sits directly upstream of the 32x32 sprite memory (1024 x 9-bit RGB, 1-cycle registered read) and directly downstream of the VGA sync/counter generator. From the current column/row it computes the sprite memory read address, consumes the returned pixel one cycle later, and applies a transparency key over a background colour. It emits 9-bit RGB with sync signals delay-matched to the pipeline, plus per-frame opaque-pixel statistics for game logic.

## Interface
- H_ACTIVE, 640, visible columns per line
- V_ACTIVE, 480, visible rows per frame
- TRANSPARENT, 9'b111_000_111, colour key; matching sprite pixels are not drawn
- i_Clk  in  1  pixel clock
- i_Rst_n  in  1  reset; asynchronous, active-low
- i_Col_Count  in  10  current column from sync generator
- i_Row_Count  in  10  current row from sync generator
- i_HSync, i_VSync  in  1 each  syncs aligned with the counts (active-low)
- i_Sprite_X, i_Sprite_Y  in  10 each  requested sprite top-left position
- i_Flip_H  in  1  requested horizontal mirror
- i_Bg_Color  in  9  background {R[2:0],G[2:0],B[2:0]}
- o_Read_Addr  out  10  sprite memory address
- i_Read_Data  in  9  sprite memory data; valid the cycle after o_Read_Addr
- o_Red, o_Green, o_Blue  out  3 each  pixel colour
- o_HSync, o_VSync  out  1 each  syncs delayed to match colour
- o_Hit  out  1  current output pixel is an opaque sprite pixel
- o_Frame_Hits  out  11  opaque sprite pixels drawn in the previous frame

## Operation
- Active = (i_Col_Count < H_ACTIVE) && (i_Row_Count < V_ACTIVE).
- Frame start = i_Row_Count == V_ACTIVE && i_Col_Count == 0 (first blanking cycle after the last visible line).
- Position latch: on frame start, {X, Y, Flip} <= {i_Sprite_X, i_Sprite_Y, i_Flip_H}. Changes mid-frame have no effect until the next frame start (no tearing).
- Inside test (11-bit unsigned, no wrap): col >= X && col < X+32 && row >= Y && row < Y+32 && Active. Sprites crossing the right/bottom edge are clipped; nothing wraps to the left/top.
- dx = col - X, dy = row - Y (low 5 bits). Address = {dy[4:0], Flip ? ~dx[4:0] : dx[4:0]}. Outside the sprite, address is don't-care; it is held at 0.
- Colour select at output stage:
  - not Active: RGB = 0, o_Hit = 0
  - Inside && i_Read_Data != TRANSPARENT: RGB = i_Read_Data, o_Hit = 1
  - otherwise: RGB = i_Bg_Color (sampled at output stage), o_Hit = 0
- Hit counter: 11-bit internal count increments on each o_Hit. On frame start: o_Frame_Hits <= count + (hit this cycle); count <= 0. Maximum is 1024; no overflow possible.

## Timing
- Stage 1 (edge 1 after inputs): o_Read_Addr, Inside, Active, syncs registered.
- Stage 2 (edge 2): memory registers i_Read_Data; Inside/Active/syncs delayed one more.
- Stage 3 (edge 3): o_Red/o_Green/o_Blue, o_Hit, o_HSync, o_VSync registered.
- Latency: 3 cycles from i_Col_Count/i_Row_Count/i_HSync/i_VSync to corresponding outputs; syncs and colour always aligned.
- o_Frame_Hits updates on the edge that registers frame start (1 cycle after frame-start inputs); held constant for a whole frame otherwise.
- Reset (asynchronous, i_Rst_n low): RGB = 0, o_Hit = 0, o_HSync = o_VSync = 1, o_Read_Addr = 0, o_Frame_Hits = 0, count = 0, latched X = Y = 1023, Flip = 0 (sprite off-screen until first frame start). All pipeline valid/inside flags cleared. Reset release mid-frame: output blank/background until the next frame start latches a position.

## Test plan
- Reset then frame start with X=100, Y=50, sprite ROM = address value mod 512 with no key colour -> at col 100,row 50 o_Read_Addr=0; 3 cycles later RGB = ROM[0]; col 131,row 81 -> addr 1023; col 132 -> background.
- i_Flip_H=1, same position -> col 100,row 50 gives addr 31; col 131 gives addr 0.
- ROM filled with TRANSPARENT except addr 0 -> exactly one pixel drawn; o_Frame_Hits = 1 after next frame start.
- X=620, Y=470 -> only cols 620..639, rows 470..479 drawn; o_Frame_Hits = 200; no pixels at col 0 or row 0.
- Change i_Sprite_X from 100 to 300 at row 200 -> rest of frame still at 100; next frame at 300.
- Assert i_Rst_n low mid-line -> all outputs at reset values immediately, before the next i_Clk edge; syncs output 3 cycles delayed after release.
